bslu_useq: RTL and testbench

BSLU_USEQ -- requirements
Module: bslu_useq

---
 rtl/bslu_pkg.sv | 50 +++++
 rtl/bslu_useq_if.sv | 23 ++
 rtl/bslu_useq_rom.sv | 44 ++++
 rtl/bslu_useq.sv | 127 ++++++++++++
 tb/tb_bslu_useq.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/bslu_pkg.sv
// Shared encodings for the bit-serial logic unit micro-sequencer:
// command opcodes, BSLU select/op codes, FSM states and the step-ROM word.
package bslu_pkg;

  typedef enum logic [1:0] {
    OPC_COPY  = 2'b00,
    OPC_NOT   = 2'b01,
    OPC_CARRY = 2'b10,
    OPC_RSVD  = 2'b11
  } opc_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    INIT = 2'b01,
    STEP = 2'b10,
    FIN  = 2'b11
  } state_e;

  // One-hot BSLU register selects
  localparam logic [2:0] SEL_NONE = 3'b000;
  localparam logic [2:0] SEL_SA   = 3'b001;
  localparam logic [2:0] SEL_CR   = 3'b010;
  localparam logic [2:0] SEL_PR   = 3'b100;

  localparam logic [4:0] OP_NONE = 5'b00000;
  localparam logic [4:0] OP_MOV  = 5'b00001;
  localparam logic [4:0] OP_SET  = 5'b00010;
  localparam logic [4:0] OP_SETV = 5'b00100;
  localparam logic [4:0] OP_MAJ  = 5'b01000;
  localparam logic [4:0] OP_NOT  = 5'b10000;
  // Set with set-value 0: clears the destination register
  localparam logic [4:0] OP_CLR  = OP_MOV | OP_SET;

  typedef enum logic [1:0] {
    BASE_A   = 2'b00,
    BASE_B   = 2'b01,
    BASE_DST = 2'b10
  } base_e;

  typedef struct packed {
    logic [2:0] rs1;
    logic [2:0] rd;
    logic [4:0] op;
    logic       row_rd;
    logic       row_wr;
    base_e      base_sel;
    logic       last_step;
  } uop_t;

endpackage

// File: rtl/bslu_useq_if.sv
// Command handshake between a host and the BSLU micro-sequencer.
interface bslu_useq_if #(
  parameter int LEN_W = 6,
  parameter int ROW_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_opc;
  logic [LEN_W-1:0] cmd_len;
  logic [ROW_W-1:0] cmd_src_a;
  logic [ROW_W-1:0] cmd_src_b;
  logic [ROW_W-1:0] cmd_dst;

  modport master (
    output cmd_valid, cmd_opc, cmd_len, cmd_src_a, cmd_src_b, cmd_dst,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_opc, cmd_len, cmd_src_a, cmd_src_b, cmd_dst,
    output cmd_ready
  );
endinterface

// File: rtl/bslu_useq_rom.sv
// Per-opcode micro-op table: maps (opcode, step within a bit) to one micro-op word.
module bslu_useq_rom
  import bslu_pkg::*;
(
  input  opc_e       opc,
  input  logic [2:0] step,
  output uop_t       uop
);

  always_comb begin
    uop = '0;
    case (opc)
      OPC_COPY: begin
        case (step)
          3'd0:    begin uop.row_rd = 1'b1; uop.base_sel = BASE_A; end
          3'd1:    begin uop.row_wr = 1'b1; uop.base_sel = BASE_DST; uop.last_step = 1'b1; end
          default: uop.last_step = 1'b1;
        endcase
      end
      OPC_NOT: begin
        case (step)
          3'd0:    begin uop.row_rd = 1'b1; uop.base_sel = BASE_A; end
          3'd1:    begin uop.op = OP_NOT; uop.rs1 = SEL_SA; uop.rd = SEL_SA; end
          3'd2:    begin uop.row_wr = 1'b1; uop.base_sel = BASE_DST; uop.last_step = 1'b1; end
          default: uop.last_step = 1'b1;
        endcase
      end
      OPC_CARRY: begin
        // cr <- maj(a, b, cr), with a parked in pr while b is loaded into sa
        case (step)
          3'd0:    begin uop.row_rd = 1'b1; uop.base_sel = BASE_A; end
          3'd1:    begin uop.op = OP_MOV; uop.rs1 = SEL_SA; uop.rd = SEL_PR; end
          3'd2:    begin uop.row_rd = 1'b1; uop.base_sel = BASE_B; end
          3'd3:    begin uop.op = OP_MAJ; uop.rd = SEL_CR; end
          3'd4:    begin uop.op = OP_MOV; uop.rs1 = SEL_CR; uop.rd = SEL_SA; end
          3'd5:    begin uop.row_wr = 1'b1; uop.base_sel = BASE_DST; uop.last_step = 1'b1; end
          default: uop.last_step = 1'b1;
        endcase
      end
      default: uop.last_step = 1'b1;
    endcase
  end

endmodule

// File: rtl/bslu_useq.sv
// BSLU micro-sequencer: expands COPY/NOT/CARRY row commands into per-bit
// micro-op streams; every output is registered one cycle behind the FSM.
module bslu_useq
  import bslu_pkg::*;
#(
  parameter int LEN_W = 6,
  parameter int ROW_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  bslu_useq_if.slave       cmd,
  output logic [2:0]       rs1,
  output logic [2:0]       rd,
  output logic [4:0]       op,
  output logic             row_rd,
  output logic             row_wr,
  output logic [ROW_W-1:0] row_addr,
  output logic             done
);

  state_e           state, state_nx;
  opc_e             opc_q;
  logic [LEN_W-1:0] len_q, bit_q;
  logic [2:0]       step_q;
  logic [ROW_W-1:0] src_a_q, src_b_q, dst_q;
  uop_t             uop;
  logic             accept, last_bit;

  logic [2:0]       rs1_d, rd_d;
  logic [4:0]       op_d;
  logic             row_rd_d, row_wr_d;
  logic [ROW_W-1:0] addr_d, base;

  bslu_useq_rom u_rom (
    .opc  (opc_q),
    .step (step_q),
    .uop  (uop)
  );

  assign accept   = cmd.cmd_valid && cmd.cmd_ready;
  assign last_bit = (bit_q == len_q - LEN_W'(1));

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = INIT;
      INIT:    state_nx = (len_q == '0) ? FIN : STEP;
      STEP:    if (uop.last_step && last_bit) state_nx = FIN;
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    rs1_d    = SEL_NONE;
    rd_d     = SEL_NONE;
    op_d     = OP_NONE;
    row_rd_d = 1'b0;
    row_wr_d = 1'b0;
    addr_d   = '0;
    case (uop.base_sel)
      BASE_B:   base = src_b_q;
      BASE_DST: base = dst_q;
      default:  base = src_a_q;
    endcase
    if (state == INIT && opc_q == OPC_CARRY) begin
      op_d = OP_CLR;
      rd_d = SEL_CR;
    end else if (state == STEP) begin
      rs1_d    = uop.rs1;
      rd_d     = uop.rd;
      op_d     = uop.op;
      row_rd_d = uop.row_rd;
      row_wr_d = uop.row_wr;
      // Address wraps modulo 2^ROW_W by plain truncation
      if (uop.row_rd || uop.row_wr) addr_d = base + ROW_W'(bit_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      opc_q         <= OPC_COPY;
      len_q         <= '0;
      bit_q         <= '0;
      step_q        <= '0;
      src_a_q       <= '0;
      src_b_q       <= '0;
      dst_q         <= '0;
      rs1           <= '0;
      rd            <= '0;
      op            <= '0;
      row_rd        <= 1'b0;
      row_wr        <= 1'b0;
      row_addr      <= '0;
      done          <= 1'b0;
      cmd.cmd_ready <= 1'b0;
    end else begin
      state         <= state_nx;
      cmd.cmd_ready <= (state_nx == IDLE);
      done          <= (state_nx == FIN);
      rs1           <= rs1_d;
      rd            <= rd_d;
      op            <= op_d;
      row_rd        <= row_rd_d;
      row_wr        <= row_wr_d;
      row_addr      <= addr_d;
      if (accept) begin
        opc_q   <= opc_e'(cmd.cmd_opc);
        len_q   <= (opc_e'(cmd.cmd_opc) == OPC_RSVD) ? '0 : cmd.cmd_len;
        src_a_q <= cmd.cmd_src_a;
        src_b_q <= cmd.cmd_src_b;
        dst_q   <= cmd.cmd_dst;
        bit_q   <= '0;
        step_q  <= '0;
      end else if (state == STEP) begin
        if (uop.last_step) begin
          step_q <= '0;
          bit_q  <= bit_q + LEN_W'(1);
        end else begin
          step_q <= step_q + 3'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bslu_useq.sv
// Directed bench for bslu_useq with a small BSLU/row-memory model.
module tb_bslu_useq;
  import bslu_pkg::*;

  localparam int LEN_W = 6;
  localparam int ROW_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [2:0]       rs1, rd;
  logic [4:0]       op;
  logic             row_rd, row_wr, done;
  logic [ROW_W-1:0] row_addr;

  always #5 clk = ~clk;

  bslu_useq_if #(.LEN_W(LEN_W), .ROW_W(ROW_W)) cmd ();

  bslu_useq #(.LEN_W(LEN_W), .ROW_W(ROW_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd      (cmd),
    .rs1      (rs1),
    .rd       (rd),
    .op       (op),
    .row_rd   (row_rd),
    .row_wr   (row_wr),
    .row_addr (row_addr),
    .done     (done)
  );

  int          errors = 0;
  int          checks = 0;
  logic [31:0] ev[$];
  int          dcyc;
  logic        mem [0:255];
  logic        sa, cr, pr;
  int          act;

  function automatic logic [31:0] e_rd(input logic [7:0] a);
    return {8'd1, 16'd0, a};
  endfunction
  function automatic logic [31:0] e_wr(input logic [7:0] a);
    return {8'd2, 16'd0, a};
  endfunction
  function automatic logic [31:0] e_op(input logic [2:0] s, input logic [2:0] d, input logic [4:0] o);
    return {8'd3, 13'd0, s, d, o};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; sample 1 time unit after the edge and apply the BSLU model
  task automatic cycle();
    logic src, v;
    @(posedge clk);
    #1;
    if (row_rd) begin ev.push_back(e_rd(row_addr)); sa = mem[row_addr]; end
    if (row_wr) begin ev.push_back(e_wr(row_addr)); mem[row_addr] = sa; end
    if (op != 5'd0 || rs1 != 3'd0 || rd != 3'd0) begin
      ev.push_back(e_op(rs1, rd, op));
      src = rs1[0] ? sa : rs1[1] ? cr : rs1[2] ? pr : 1'b0;
      if (op[1])      v = op[2];
      else if (op[3]) v = (sa & cr) | (sa & pr) | (cr & pr);
      else if (op[4]) v = ~src;
      else            v = src;
      if (rd[0]) sa = v;
      if (rd[1]) cr = v;
      if (rd[2]) pr = v;
    end
  endtask

  task automatic run_cmd(input logic [1:0] opc, input logic [5:0] len,
                         input logic [7:0] a, input logic [7:0] b, input logic [7:0] d,
                         input bit hold);
    ev.delete();
    dcyc = 0;
    check("ready_before_accept", cmd.cmd_ready, 1'b1);
    cmd.cmd_valid = 1'b1;
    cmd.cmd_opc   = opc;
    cmd.cmd_len   = len;
    cmd.cmd_src_a = a;
    cmd.cmd_src_b = b;
    cmd.cmd_dst   = d;
    for (int c = 1; c <= 100; c++) begin
      cycle();
      if (c == 1) begin
        if (hold) begin
          cmd.cmd_opc   = 2'b10;
          cmd.cmd_len   = 6'd9;
          cmd.cmd_src_a = 8'd200;
          cmd.cmd_dst   = 8'd201;
        end else begin
          cmd.cmd_valid = 1'b0;
        end
      end
      if (done) begin
        dcyc = c;
        break;
      end
    end
    cmd.cmd_valid = 1'b0;
    cycle();
    check("done_one_cycle", done, 1'b0);
    check("ready_after_done", cmd.cmd_ready, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cmd.cmd_valid = 1'b0;
    cmd.cmd_opc   = 2'b00;
    cmd.cmd_len   = '0;
    cmd.cmd_src_a = '0;
    cmd.cmd_src_b = '0;
    cmd.cmd_dst   = '0;
    sa = 1'b0; cr = 1'b0; pr = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;

    // Reset state
    repeat (3) begin @(posedge clk); #1; end
    check("rst_ready_low", cmd.cmd_ready, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_outs", {rs1, rd, op, row_rd, row_wr, row_addr}, '0);
    rst_n = 1'b1;
    cycle();
    check("ready_first_edge", cmd.cmd_ready, 1'b1);

    // COPY len=3 src_a=10 dst=20, rows 10..12 = 1,0,1
    mem[10] = 1'b1; mem[11] = 1'b0; mem[12] = 1'b1;
    run_cmd(2'b00, 6'd3, 8'd10, 8'd0, 8'd20, 1'b0);
    check("copy_nev", ev.size(), 6);
    check("copy_ev0", ev[0], e_rd(8'd10));
    check("copy_ev1", ev[1], e_wr(8'd20));
    check("copy_ev2", ev[2], e_rd(8'd11));
    check("copy_ev3", ev[3], e_wr(8'd21));
    check("copy_ev4", ev[4], e_rd(8'd12));
    check("copy_ev5", ev[5], e_wr(8'd22));
    check("copy_done_cyc", dcyc, 8);
    check("copy_data", {mem[20], mem[21], mem[22]}, 3'b101);

    // NOT len=1: row 5 holds 1, row 30 must receive 0
    mem[5] = 1'b1; mem[30] = 1'b1;
    run_cmd(2'b01, 6'd1, 8'd5, 8'd0, 8'd30, 1'b0);
    check("not_nev", ev.size(), 3);
    check("not_ev0", ev[0], e_rd(8'd5));
    check("not_ev1", ev[1], e_op(3'b001, 3'b001, 5'b10000));
    check("not_ev2", ev[2], e_wr(8'd30));
    check("not_done_cyc", dcyc, 5);
    check("not_data", mem[30], 1'b0);

    // CARRY len=4, A=1011 at rows 40..43, B=0110 at rows 50..53 (LSB first)
    mem[40] = 1'b1; mem[41] = 1'b1; mem[42] = 1'b0; mem[43] = 1'b1;
    mem[50] = 1'b0; mem[51] = 1'b1; mem[52] = 1'b1; mem[53] = 1'b0;
    cr = 1'b1;
    run_cmd(2'b10, 6'd4, 8'd40, 8'd50, 8'd60, 1'b0);
    check("carry_nev", ev.size(), 25);
    check("carry_init", ev[0], e_op(3'b000, 3'b010, 5'b00011));
    check("carry_s0", ev[1], e_rd(8'd40));
    check("carry_s1", ev[2], e_op(3'b001, 3'b100, 5'b00001));
    check("carry_s2", ev[3], e_rd(8'd50));
    check("carry_s3", ev[4], e_op(3'b000, 3'b010, 5'b01000));
    check("carry_s4", ev[5], e_op(3'b010, 3'b001, 5'b00001));
    check("carry_s5", ev[6], e_wr(8'd60));
    check("carry_last_wr", ev[24], e_wr(8'd63));
    check("carry_done_cyc", dcyc, 26);
    check("carry_bits", {mem[63], mem[62], mem[61], mem[60]}, 4'b1110);

    // Row address wrap at 2^ROW_W
    run_cmd(2'b00, 6'd4, 8'd254, 8'd0, 8'd100, 1'b0);
    check("wrap_nev", ev.size(), 8);
    check("wrap_a0", ev[0], e_rd(8'd254));
    check("wrap_a1", ev[2], e_rd(8'd255));
    check("wrap_a2", ev[4], e_rd(8'd0));
    check("wrap_a3", ev[6], e_rd(8'd1));
    check("wrap_done_cyc", dcyc, 10);

    // Zero-length and reserved-opcode commands
    run_cmd(2'b00, 6'd0, 8'd1, 8'd2, 8'd3, 1'b0);
    check("len0_nev", ev.size(), 0);
    check("len0_done_cyc", dcyc, 2);
    run_cmd(2'b11, 6'd5, 8'd1, 8'd2, 8'd3, 1'b0);
    check("rsvd_nev", ev.size(), 0);
    check("rsvd_done_cyc", dcyc, 2);
    run_cmd(2'b10, 6'd0, 8'd1, 8'd2, 8'd3, 1'b0);
    check("carry0_nev", ev.size(), 1);
    check("carry0_init", ev[0], e_op(3'b000, 3'b010, 5'b00011));
    check("carry0_done_cyc", dcyc, 2);

    // cmd_valid held while busy with changing fields: single accept, latched fields
    run_cmd(2'b00, 6'd1, 8'd7, 8'd0, 8'd8, 1'b1);
    check("hold_nev", ev.size(), 2);
    check("hold_ev0", ev[0], e_rd(8'd7));
    check("hold_ev1", ev[1], e_wr(8'd8));
    check("hold_done_cyc", dcyc, 4);
    cycle();
    check("hold_idle", {cmd.cmd_ready, done, row_rd, row_wr}, 4'b1000);

    // Reset during step 3 of a CARRY command
    ev.delete();
    cmd.cmd_valid = 1'b1;
    cmd.cmd_opc   = 2'b10;
    cmd.cmd_len   = 6'd2;
    cmd.cmd_src_a = 8'd80;
    cmd.cmd_src_b = 8'd90;
    cmd.cmd_dst   = 8'd95;
    cycle();
    cmd.cmd_valid = 1'b0;
    repeat (4) cycle();
    check("rst_mid_pre", {row_rd, row_addr}, {1'b1, 8'd90});
    rst_n = 1'b0;
    #1;
    check("rst_mid_outs", {rs1, rd, op, row_rd, row_wr, row_addr, done}, '0);
    check("rst_mid_ready", cmd.cmd_ready, 1'b0);
    repeat (2) cycle();
    check("rst_mid_hold", {cmd.cmd_ready, done}, 2'b00);
    rst_n = 1'b1;
    ev.delete();
    cycle();
    check("rst_mid_release", cmd.cmd_ready, 1'b1);
    act = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (done || !cmd.cmd_ready) act++;
    end
    check("rst_mid_quiet", act, 0);
    check("rst_mid_nev", ev.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
